uart_tx: RTL

- 8N1 UART transmitter: serializes one byte per valid/ready handshake onto a single line, LSB first.
- Drives the FPGA UART TX pin on the board top; runs in the 50 MHz PLL domain.
- Pairs with the existing UART receive path. It returns ALU results and status bytes to the host.
- Bit timing comes from an internal clocks-per-bit counter; no external baud tick.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and the
// baud-rate divisor rule used by both the transmit and receive paths.
package uart_pkg;

   localparam int DataBits = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   // Clock cycles per serial bit, rounded to the nearest integer.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-running cycle counter that restarts on clear and
// pulses bit_done_o for one cycle at the last cycle of every bit period.
module uart_bit_timer #(
   parameter int ClksPerBit = 434
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic bit_done_o
);

   localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      bit_done_o = (cnt_q == LastCnt);
      cnt_d      = cnt_q + CntW'(1);
      if (clear_i || bit_done_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts one byte per valid/ready handshake and shifts
// it out LSB first between a low start bit and a high stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int ClkFreqHz = 50_000_000,
   parameter int BaudRate  = 115200
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o
);

   localparam int ClksPerBit = clks_per_bit(ClkFreqHz, BaudRate);
   localparam logic [2:0] LastBit = 3'(DataBits - 1);

   if (ClksPerBit < 2) begin : g_bad_cfg
      $fatal(1, "uart_tx: ClksPerBit must be at least 2");
   end

   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       tx_q, tx_d;
   logic       accept;
   logic       bit_done;

   uart_bit_timer #(
      .ClksPerBit(ClksPerBit)
   ) u_bit_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (accept),
      .bit_done_o(bit_done)
   );

   // A held valid_i is also taken on the last stop-bit cycle, so back-to-back
   // frames follow with no idle gap while ready_o still reflects only IDLE.
   always_comb begin
      ready_o   = (state_q == IDLE) && !rst_i;
      accept    = valid_i && !rst_i &&
                  ((state_q == IDLE) || ((state_q == STOP) && bit_done));
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
         end
         START: begin
            if (bit_done) begin
               state_d   = DATA;
               bit_idx_d = '0;
               tx_d      = shift_q[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               if (bit_idx_q == LastBit) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_done) begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (accept) begin
         state_d   = START;
         shift_d   = data_i;
         bit_idx_d = '0;
         tx_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = (state_q != IDLE);

endmodule
